// File: rtl/down_count_sequencer.sv
// Timer sequencer around an Nbits binary down-counter with prescaled ticks.
// Supports one-shot and auto-reload modes, plus pause/resume and abort.
module down_count_sequencer #(
    parameter int Nbits      = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [Nbits-1:0]      load_val,
    input  logic                  reload,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  pause,
    input  logic                  abort,
    output logic                  ready,
    output logic                  busy,
    output logic [Nbits-1:0]      count,
    output logic                  tc,
    output logic                  done,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t                state_r;
    logic [Nbits-1:0]      load_r;
    logic                  reload_r;
    logic [PRESCALE_W-1:0] psc_r;
    logic [PRESCALE_W-1:0] psc_cnt_r;
    logic                  tick_s;
    logic                  last_s;

    assign state  = state_r;
    assign tick_s = (psc_cnt_r == psc_r);
    // A count of 0 is treated like 1 so that load_val=0 terminates on the first tick.
    assign last_s = (count <= Nbits'(1));

    // Sequencer state, counter datapath, prescaler and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            count     <= {Nbits{1'b0}};
            psc_cnt_r <= {PRESCALE_W{1'b0}};
            psc_r     <= {PRESCALE_W{1'b0}};
            load_r    <= {Nbits{1'b0}};
            reload_r  <= 1'b0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            tc        <= 1'b0;
            done      <= 1'b0;
        end else begin
            tc   <= 1'b0;
            done <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (abort) begin
                        state_r   <= IDLE;
                        count     <= {Nbits{1'b0}};
                        psc_cnt_r <= {PRESCALE_W{1'b0}};
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                    end else if (start) begin
                        load_r    <= load_val;
                        reload_r  <= reload;
                        psc_r     <= prescale;
                        count     <= load_val;
                        psc_cnt_r <= {PRESCALE_W{1'b0}};
                        state_r   <= RUN;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_r   <= IDLE;
                        count     <= {Nbits{1'b0}};
                        psc_cnt_r <= {PRESCALE_W{1'b0}};
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                    end else if (pause) begin
                        state_r <= PAUSE;
                    end else if (tick_s) begin
                        psc_cnt_r <= {PRESCALE_W{1'b0}};
                        if (!last_s) begin
                            count <= count - Nbits'(1);
                        end else if (reload_r) begin
                            count <= load_r;
                            tc    <= 1'b1;
                        end else begin
                            count   <= {Nbits{1'b0}};
                            tc      <= 1'b1;
                            done    <= 1'b1;
                            state_r <= DONE;
                            ready   <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end else begin
                        psc_cnt_r <= psc_cnt_r + PRESCALE_W'(1);
                    end
                end
                PAUSE: begin
                    if (abort) begin
                        state_r   <= IDLE;
                        count     <= {Nbits{1'b0}};
                        psc_cnt_r <= {PRESCALE_W{1'b0}};
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                    end else if (!pause) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= PAUSE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    count     <= {Nbits{1'b0}};
                    psc_cnt_r <= {PRESCALE_W{1'b0}};
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_count_sequencer.sv
// Directed self-checking bench for down_count_sequencer (Nbits=4, PRESCALE_W=8).
module tb_down_count_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] load_val;
    logic       reload;
    logic [7:0] prescale;
    logic       pause;
    logic       abort;
    logic       ready;
    logic       busy;
    logic [3:0] count;
    logic       tc;
    logic       done;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    down_count_sequencer #(.Nbits(4), .PRESCALE_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val), .reload(reload),
        .prescale(prescale), .pause(pause), .abort(abort), .ready(ready), .busy(busy),
        .count(count), .tc(tc), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    // One active edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; load_val = 4'd5; reload = 1'b0; prescale = 8'd0;
        pause = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({state, count, ready, busy, tc, done} !== {2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset cyc%0d: state=%b count=%0d ready=%b busy=%b tc=%b done=%b, want 00 0 1 0 0 0",
                         i, state, count, ready, busy, tc, done);
            end
        end
        rst = 1'b0; start = 1'b0;
        step();
        checks++;
        if (state !== 2'b00 || count !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle: state=%b count=%0d, want 00 0", state, count);
        end
    endtask

    task automatic test_oneshot();
        load_val = 4'd5; reload = 1'b0; prescale = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({state, count, busy, ready, tc} !== {2'b01, 4'd5, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL oneshot_accept: state=%b count=%0d busy=%b ready=%b tc=%b, want 01 5 1 0 0",
                     state, count, busy, ready, tc);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (count !== 4'(5 - k) || tc !== (k == 5) || done !== (k == 5)) begin
                errors++;
                $display("FAIL oneshot_E%0d: count=%0d tc=%b done=%b, want %0d %b %b",
                         k, count, tc, done, 5 - k, (k == 5), (k == 5));
            end
        end
        checks++;
        if (state !== 2'b11 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_done_state: state=%b ready=%b busy=%b, want 11 1 0", state, ready, busy);
        end
        step();
        checks++;
        if ({state, count, tc, done} !== {2'b11, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL oneshot_pulse_width: state=%b count=%0d tc=%b done=%b, want 11 0 0 0",
                     state, count, tc, done);
        end
    endtask

    task automatic test_autoreload();
        logic [3:0] exp_cnt [0:12];
        exp_cnt = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd3};
        load_val = 4'd3; reload = 1'b1; prescale = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) step();
            checks++;
            if (count !== exp_cnt[k] || tc !== (k == 6 || k == 12) || done !== 1'b0 || state !== 2'b01) begin
                errors++;
                $display("FAIL autoreload_E%0d: count=%0d tc=%b done=%b state=%b, want %0d %b 0 01",
                         k, count, tc, done, state, exp_cnt[k], (k == 6 || k == 12));
            end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({state, count, ready, tc} !== {2'b00, 4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL autoreload_abort: state=%b count=%0d ready=%b tc=%b, want 00 0 1 0",
                     state, count, ready, tc);
        end
    endtask

    task automatic test_pause();
        load_val = 4'd8; reload = 1'b0; prescale = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) step();
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL pause_pre: count=%0d, want 5", count);
        end
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({state, count, busy, tc, done} !== {2'b10, 4'd5, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL pause_hold%0d: state=%b count=%0d busy=%b tc=%b done=%b, want 10 5 1 0 0",
                         i, state, count, busy, tc, done);
            end
        end
        pause = 1'b0;
        step();
        checks++;
        if (state !== 2'b01 || count !== 4'd5) begin
            errors++;
            $display("FAIL pause_resume: state=%b count=%0d, want 01 5", state, count);
        end
        for (int k = 9; k <= 13; k++) begin
            step();
            checks++;
            if (count !== 4'(13 - k) || done !== (k == 13) || tc !== (k == 13)) begin
                errors++;
                $display("FAIL pause_E%0d: count=%0d done=%b tc=%b, want %0d %b %b",
                         k, count, done, tc, 13 - k, (k == 13), (k == 13));
            end
        end
    endtask

    task automatic test_abort();
        load_val = 4'd6; reload = 1'b0; prescale = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (tc !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL abort_run_pulse: tc=%b done=%b, want 0 0", tc, done);
            end
        end
        checks++;
        if (count !== 4'd2) begin
            errors++;
            $display("FAIL abort_pre: count=%0d, want 2", count);
        end
        abort = 1'b1;
        step();
        checks++;
        if ({state, count, ready, busy, tc, done} !== {2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_run: state=%b count=%0d ready=%b busy=%b tc=%b done=%b, want 00 0 1 0 0 0",
                     state, count, ready, busy, tc, done);
        end
        start = 1'b1; load_val = 4'd7;
        step();
        abort = 1'b0; start = 1'b0;
        checks++;
        if ({state, count, busy} !== {2'b00, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL abort_with_start: state=%b count=%0d busy=%b, want 00 0 0", state, count, busy);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({state, tc, done} !== {2'b00, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL abort_quiet%0d: state=%b tc=%b done=%b, want 00 0 0", i, state, tc, done);
            end
        end
    endtask

    task automatic test_start_while_busy();
        load_val = 4'd4; reload = 1'b0; prescale = 8'd0; start = 1'b1;
        step();
        load_val = 4'd9; reload = 1'b1; prescale = 8'd5;
        for (int k = 1; k <= 4; k++) begin
            if (k == 3) start = 1'b0;
            step();
            checks++;
            if (count !== 4'(4 - k) || done !== (k == 4)) begin
                errors++;
                $display("FAIL busy_start_E%0d: count=%0d done=%b, want %0d %b", k, count, done, 4 - k, (k == 4));
            end
        end
        checks++;
        if (state !== 2'b11) begin
            errors++;
            $display("FAIL busy_start_done: state=%b, want 11", state);
        end
    endtask

    task automatic test_zero_load();
        load_val = 4'd0; reload = 1'b0; prescale = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) step();
            checks++;
            if (count !== 4'd0 || tc !== (k == 3) || done !== (k == 3) ||
                state !== ((k == 3) ? 2'b11 : 2'b01)) begin
                errors++;
                $display("FAIL zero_load_E%0d: count=%0d tc=%b done=%b state=%b, want 0 %b %b %b",
                         k, count, tc, done, state, (k == 3), (k == 3), ((k == 3) ? 2'b11 : 2'b01));
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_pause();
        test_abort();
        test_start_while_busy();
        test_zero_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
